mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port 16-bit memory responder: one request at a time, mem_resp LATENCY cycles after acceptance.
// No backpressure; the initiator holds its request until mem_resp and may abort by dropping it while busy.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_error
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ILL} op_t;

  state_t               state_q;
  op_t                  op_q;
  op_t                  req_op;
  op_t                  fin_op;
  logic [3:0]           cnt_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [ADDR_BITS-1:0] req_idx;
  logic [ADDR_BITS-1:0] fin_idx;
  logic [15:0]          wdata_q;
  logic [1:0]           be_q;
  logic [15:0]          rdata_q;
  logic [15:0]          fin_rdata;
  logic                 resp_q;
  logic                 err_q;
  logic                 unused_addr;

  logic [15:0] mem_q [DEPTH] = '{default: '0};

  assign unused_addr = ^mem_address;

  // Address/op feeding the RESP entry: live inputs when going straight from IDLE (LATENCY=1).
  always_comb begin
    req_idx = mem_address[ADDR_BITS:1];
    if (mem_read && mem_write) begin
      req_op = OP_ILL;
    end else if (mem_write) begin
      req_op = OP_WRITE;
    end else begin
      req_op = OP_READ;
    end
    fin_op  = (state_q == IDLE) ? req_op  : op_q;
    fin_idx = (state_q == IDLE) ? req_idx : idx_q;
    case (fin_op)
      OP_READ: fin_rdata = mem_q[fin_idx];
      OP_ILL:  fin_rdata = '0;
      default: fin_rdata = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_q    <= req_op;
            idx_q   <= req_idx;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            if (LATENCY == 1) begin
              state_q <= RESP;
              cnt_q   <= '0;
              rdata_q <= fin_rdata;
              resp_q  <= 1'b1;
              err_q   <= (req_op == OP_ILL);
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (!mem_read && !mem_write) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd1) begin
            // counter reaches 0 on this edge: response lands LATENCY cycles after acceptance
            state_q <= RESP;
            cnt_q   <= '0;
            rdata_q <= fin_rdata;
            resp_q  <= 1'b1;
            err_q   <= (op_q == OP_ILL);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && op_q == OP_WRITE) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  // Reset masks the outputs immediately, including a RESP cycle it lands in.
  assign mem_rdata = reset ? 16'h0000 : rdata_q;
  assign mem_resp  = resp_q & ~reset;
  assign mem_error = err_q & ~reset;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level model plus directed literal checks.
module tb_mem_responder;

  localparam int AB = 8;
  localparam int L  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [15:0] addr = 16'h0, wd = 16'h0;
  logic [15:0] rdata;
  logic        resp, err;

  logic        r1_rd = 1'b0, r1_wr = 1'b0;
  logic [1:0]  r1_be = 2'b00;
  logic [15:0] r1_addr = 16'h0, r1_wd = 16'h0;
  logic [15:0] r1_rdata;
  logic        r1_resp, r1_err;

  mem_responder #(.ADDR_BITS(AB), .LATENCY(L)) u_dut (
    .clk(clk), .reset(reset), .mem_read(rd), .mem_write(wr),
    .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wd),
    .mem_rdata(rdata), .mem_resp(resp), .mem_error(err)
  );

  mem_responder #(.ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(r1_rd), .mem_write(r1_wr),
    .mem_byte_enable(r1_be), .mem_address(r1_addr), .mem_wdata(r1_wd),
    .mem_rdata(r1_rdata), .mem_resp(r1_resp), .mem_error(r1_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model state
  logic [15:0] m_mem [1<<AB];
  logic [15:0] cur_rdata = 16'h0;
  logic [15:0] exp_rdata = 16'h0;
  logic        exp_ill = 1'b0;
  int          exp_resp_cyc = -1;
  int          txn_t = 0;
  int          last_resp_cyc = -1;
  logic [15:0] last_rdata = 16'h0;
  logic        last_err = 1'b0;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    logic e_resp;
    e_resp = !reset && (cyc == exp_resp_cyc);
    if (chk_en) begin
      chk("resp", resp, e_resp);
      chk("error", err, e_resp && exp_ill);
      if (reset) chk("rdata_in_reset", rdata, 32'h0);
      else if (e_resp) chk("rdata", rdata, exp_rdata);
      if (resp) begin
        last_resp_cyc = cyc;
        last_rdata    = rdata;
        last_err      = err;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read, 1 write, 2 both (illegal). abort_k/rst_k: cycle offset of abort/reset, 0 = none.
  task automatic do_txn(input int kind, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] b, input int abort_k, input int rst_k);
    int idx;
    idx   = int'(a[AB:1]);
    txn_t = cyc;
    rd = (kind != 1); wr = (kind != 0); addr = a; wd = d; be = b;
    exp_ill      = (kind == 2);
    exp_rdata    = (kind == 0) ? m_mem[idx] : (kind == 2) ? 16'h0000 : cur_rdata;
    exp_resp_cyc = (abort_k == 0 && (rst_k == 0 || rst_k == L)) ? txn_t + L : -1;
    for (int k = 1; k <= L; k++) begin
      step();
      if (k == abort_k) begin
        rd = 1'b0; wr = 1'b0;
        step();
        return;
      end
      if (k == rst_k) begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0;
        step();
        reset = 1'b0;
        cur_rdata = 16'h0;
        return;
      end
      if (k < L) begin
        addr = 16'($urandom); wd = 16'($urandom); be = 2'($urandom);
        case ($urandom_range(0, 2))
          0:       begin rd = 1'b1; wr = 1'b0; end
          1:       begin rd = 1'b0; wr = 1'b1; end
          default: begin rd = 1'b1; wr = 1'b1; end
        endcase
      end
    end
    if (kind == 1) begin
      if (b[0]) m_mem[idx][7:0]  = d[7:0];
      if (b[1]) m_mem[idx][15:8] = d[15:8];
    end else if (kind == 0) begin
      cur_rdata = m_mem[idx];
    end else begin
      cur_rdata = 16'h0;
    end
    step();
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int kind, ab, rk, r;
    logic [15:0] a;
    for (int i = 0; i < (1 << AB); i++) m_mem[i] = 16'h0;

    step();
    chk_en = 1'b1;
    step(); step();
    reset = 1'b0;

    // first request in the first cycle out of reset
    do_txn(1, 16'h0040, 16'hBEEF, 2'b11, 0, 0);
    chk("wr_latency", last_resp_cyc - txn_t, 3);
    do_txn(0, 16'h0040, 16'h0000, 2'b00, 0, 0);
    chk("rd_latency", last_resp_cyc - txn_t, 3);
    chk("rd_beef", last_rdata, 16'hBEEF);
    chk("rd_beef_err", last_err, 1'b0);

    do_txn(1, 16'h0010, 16'h1234, 2'b11, 0, 0);
    do_txn(1, 16'h0010, 16'hABCD, 2'b01, 0, 0);
    do_txn(0, 16'h0010, 16'h0000, 2'b00, 0, 0);
    chk("lane0", last_rdata, 16'h12CD);
    do_txn(1, 16'h0011, 16'hAB00, 2'b10, 0, 0);
    do_txn(0, 16'h0010, 16'h0000, 2'b00, 0, 0);
    chk("lane1", last_rdata, 16'hABCD);

    do_txn(1, 16'h0002, 16'h7777, 2'b11, 0, 0);
    do_txn(2, 16'h0002, 16'h1111, 2'b11, 0, 0);
    chk("ill_latency", last_resp_cyc - txn_t, 3);
    chk("ill_err", last_err, 1'b1);
    chk("ill_rdata", last_rdata, 16'h0000);
    do_txn(0, 16'h0002, 16'h0000, 2'b00, 0, 0);
    chk("ill_nochange", last_rdata, 16'h7777);

    last_resp_cyc = -1;
    do_txn(1, 16'h0040, 16'h9999, 2'b11, 1, 0);
    chk("abort_noresp", last_resp_cyc, -1);
    do_txn(0, 16'h0040, 16'h0000, 2'b00, 0, 0);
    chk("abort_keep", last_rdata, 16'hBEEF);

    last_resp_cyc = -1;
    do_txn(1, 16'h0040, 16'h5555, 2'b11, 0, L);
    chk("rst_resp_noresp", last_resp_cyc, -1);
    chk("rst_rdata", rdata, 16'h0000);
    do_txn(0, 16'h0040, 16'h0000, 2'b00, 0, 0);
    chk("rst_keep", last_rdata, 16'hBEEF);
    do_txn(0, 16'h0010, 16'h0000, 2'b00, 0, 0);
    chk("rst_retain", last_rdata, 16'hABCD);

    do_txn(1, 16'h0000, 16'hC0DE, 2'b11, 0, 0);
    do_txn(0, 16'h0200, 16'h0000, 2'b00, 0, 0);
    chk("alias", last_rdata, 16'hC0DE);

    for (int n = 0; n < 300; n++) begin
      kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[8:1] = 8'($urandom_range(0, 7));
      ab = 0; rk = 0;
      r = int'($urandom_range(0, 19));
      if (r < 2) ab = int'($urandom_range(1, L - 1));
      else if (r == 2) rk = int'($urandom_range(1, L));
      do_txn(kind, a, 16'($urandom), 2'($urandom), ab, rk);
      repeat ($urandom_range(0, 2)) begin
        addr = 16'($urandom);
        step();
      end
    end

    // LATENCY=1 instance: direct IDLE->RESP, alias, back-to-back held request
    r1_wr = 1'b1; r1_addr = 16'h0000; r1_wd = 16'h1357; r1_be = 2'b11;
    chk("l1_idle", r1_resp, 1'b0);
    step();
    chk("l1_wr_resp", r1_resp, 1'b1);
    r1_wr = 1'b0;
    step();
    chk("l1_after", r1_resp, 1'b0);
    r1_rd = 1'b1; r1_addr = 16'h0200;
    step();
    chk("l1_rd_resp", r1_resp, 1'b1);
    chk("l1_alias", r1_rdata, 16'h1357);
    chk("l1_err", r1_err, 1'b0);
    step();
    chk("l1_gap", r1_resp, 1'b0);
    step();
    chk("l1_repeat", r1_resp, 1'b1);
    r1_rd = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
